// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams a length-prefixed image into instruction memory, then releases the core.
// Optional trailing checksum byte enabled by defining IMEM_BOOT_CKSUM_EN.
module imem_boot_ctrl #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_core_hold,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
`ifdef IMEM_BOOT_CKSUM_EN
  localparam logic [2:0] ST_CKSUM = 3'd2;
`endif
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  logic [2:0]      state_reg;
  logic [2:0]      state_next;
  logic [ADDR_W:0] len_reg;
  logic [ADDR_W:0] count_reg;
  logic            busy;
  logic            hs;
  logic            start_ok;
  logic            len_bad;
  logic            last_byte;

`ifdef IMEM_BOOT_CKSUM_EN
  logic [7:0]      sum_reg;
  assign busy = (state_reg == ST_LOAD) || (state_reg == ST_CKSUM);
`else
  assign busy = (state_reg == ST_LOAD);
`endif

  // Ready comes straight from the state register so valid never loops back combinationally.
  assign o_byte_ready = busy;
  assign hs           = i_byte_valid & busy;
  assign start_ok     = i_start & ~busy;
  assign len_bad      = (i_len == '0) || (i_len > MAX_LEN);
  assign last_byte    = (count_reg == (len_reg - ONE));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: begin
        if (hs && last_byte) begin
`ifdef IMEM_BOOT_CKSUM_EN
          state_next = ST_CKSUM;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef IMEM_BOOT_CKSUM_EN
      ST_CKSUM: begin
        if (hs) state_next = (i_byte_data == sum_reg) ? ST_DONE : ST_ERR;
      end
`endif
      default: begin
        if (i_start) state_next = len_bad ? ST_ERR : ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      count_reg   <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_core_hold <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      // Status flags track the next state so they line up with the state change.
      o_core_hold <= (state_next != ST_DONE);
      o_done      <= (state_next == ST_DONE);
      o_err       <= (state_next == ST_ERR);
      o_mem_we    <= 1'b0;
      if (start_ok) begin
        len_reg   <= i_len;
        count_reg <= '0;
      end
      if (hs && (state_reg == ST_LOAD)) begin
        o_mem_we    <= 1'b1;
        o_mem_addr  <= count_reg[ADDR_W-1:0];
        o_mem_wdata <= i_byte_data;
        count_reg   <= count_reg + ONE;
      end
    end
  end

`ifdef IMEM_BOOT_CKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_reg <= '0;
    end else if (start_ok) begin
      sum_reg <= '0;
    end else if (hs && (state_reg == ST_LOAD)) begin
      sum_reg <= sum_reg + i_byte_data;
    end
  end
`endif

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-time loader that fills the byte-wide instruction memory from an external byte stream before the single-cycle core runs. Holds the core in stall from reset, accepts a length-prefixed program over a valid/ready byte interface, and writes it little-endian byte-by-byte from address 0. Releases the core when the image is complete, or flags an error. Sits between the debug/boot link and the instruction memory's write port; the fetch path is untouched.

## Interface
- MEM_BYTES, 2048, instruction memory size in bytes
- ADDR_W, 11, byte-address width (log2 MEM_BYTES)
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse: begin a load; sampled only in IDLE, DONE, ERR
- i_len  input  ADDR_W+1  payload byte count, latched on accepted i_start
- i_byte_valid  input  1  stream byte valid
- i_byte_data  input  8  stream byte
- o_byte_ready  output  1  controller can accept a byte this cycle
- o_mem_we  output  1  instruction memory byte write strobe
- o_mem_addr  output  ADDR_W  byte write address
- o_mem_wdata  output  8  byte write data
- o_core_hold  output  1  stall/hold core (PC frozen at 0)
- o_done  output  1  image loaded, core released
- o_err  output  1  load failed (bad length or checksum)

## Operation
- States: IDLE, LOAD, CKSUM (only with macro), DONE, ERR.
- IDLE: reset state. i_start -> latch i_len into len_q, clear count/sum; if i_len==0 or i_len>MEM_BYTES -> ERR, else -> LOAD.
- LOAD: o_byte_ready=1. Handshake = i_byte_valid & o_byte_ready. Each handshake: write byte at address count, count++, sum += byte (mod 256). When handshake with count==len_q-1 -> DONE (or CKSUM with macro).
- CKSUM: o_byte_ready=1; next handshaken byte compared with sum; equal -> DONE, else -> ERR. Byte is not written to memory.
- DONE: o_done=1, o_core_hold=0. i_start -> reload as from IDLE (hold reasserts next cycle).
- ERR: o_err=1, o_core_hold=1. Sticky until i_start (retry as from IDLE) or reset.
- i_start in LOAD/CKSUM ignored. Bytes offered outside LOAD/CKSUM are not accepted (ready=0).
- Count is ADDR_W+1 bits; len_q==MEM_BYTES fills addresses 0..MEM_BYTES-1, no wrap.

## Timing
- All outputs registered except o_byte_ready (decoded from state register, no combinational path from i_byte_valid).
- Reset values: o_byte_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_core_hold=1, o_done=0, o_err=0.
- Write latency: handshake in cycle N -> o_mem_we=1 with addr/data in cycle N+1, exactly one cycle per byte; back-to-back bytes give back-to-back writes.
- i_start in cycle N -> state LOAD (ready=1) in N+1; bad length -> o_err=1 in N+1.
- Final payload handshake in cycle N -> last write and o_done=1 / o_core_hold=0 both in N+1 (no macro).
- Reset asserted mid-load: immediate return to IDLE, hold=1, we=0; memory contents left partial; no resume.

## Configuration
- IMEM_BOOT_CKSUM_EN defined: CKSUM state present; one trailing byte after payload must equal 8-bit sum of payload bytes; mismatch -> ERR, hold stays 1.
- Not defined: CKSUM state absent; DONE entered directly after last payload byte; no trailing byte consumed.

## Test plan
- Reset, i_start with i_len=8, bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 back-to-back -> writes addr 0..7 with those bytes, one per cycle, o_done=1 and o_core_hold=0 one cycle after last handshake (macro off).
- Same image with i_byte_valid toggling every other cycle -> identical write sequence, no duplicate or dropped writes, o_mem_we only after handshakes.
- i_len=0 and i_len=2049 -> o_err=1 next cycle, o_byte_ready stays 0, no writes; subsequent i_start with i_len=4 completes normally.
- Macro on: 4 bytes 0x01,0x02,0x03,0x04 then 0x0A -> DONE; same payload then 0x0B -> ERR, o_core_hold=1, 4 writes only.
- Reset pulsed after 3 of 8 bytes -> outputs return to reset values immediately; fresh load of i_len=2048 fills addresses 0..2047 and ends in DONE without address wrap.
